// File: rtl/fwd_bypass_net_if.sv
// Bus bundle between the ID/EX pipeline control (master) and the EX-stage forwarding network (slave).
interface fwd_bypass_net_if #(
    parameter int XLEN  = 32,
    parameter int RBITS = 5,
    parameter int DEPTH = 3,
    parameter int NSRC  = 2
);
    localparam int SBITS = $clog2(DEPTH + 1);

    logic                  advance;
    logic                  flush;
    logic                  push_valid;
    logic [RBITS-1:0]      push_rd;
    logic [XLEN-1:0]       push_data;
    logic                  push_is_load;
    logic [XLEN-1:0]       mem_rdata;
    logic [NSRC-1:0]       src_en;
    logic [NSRC*RBITS-1:0] src_rs;
    logic [NSRC*XLEN-1:0]  rf_data;
    logic [NSRC*XLEN-1:0]  src_data;
    logic [NSRC*SBITS-1:0] src_sel;
    logic                  stall;

    modport master (
        output advance, flush, push_valid, push_rd, push_data, push_is_load,
               mem_rdata, src_en, src_rs, rf_data,
        input  src_data, src_sel, stall
    );

    modport slave (
        input  advance, flush, push_valid, push_rd, push_data, push_is_load,
               mem_rdata, src_en, src_rs, rf_data,
        output src_data, src_sel, stall
    );
endinterface

// File: rtl/fwd_bypass_net.sv
// EX-stage operand forwarding: DEPTH-deep result history, youngest-wins lookup, load-use stall.
// Optional FWD_STATS_EN adds saturating fwd_hits / stall_cycles counters.
module fwd_bypass_net #(
    parameter int XLEN  = 32,
    parameter int RBITS = 5,
    parameter int DEPTH = 3,
    parameter int NSRC  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    fwd_bypass_net_if.slave  bus
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]      fwd_hits,
    output logic [31:0]      stall_cycles
`endif
);
    localparam int SBITS = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] h_v;
    logic [RBITS-1:0] h_rd   [DEPTH];
    logic [XLEN-1:0]  h_data [DEPTH];
    // Only the youngest entry can be waiting on load data.
    logic             pend0;

    logic [NSRC-1:0]  hit;
    logic [NSRC-1:0]  hazard;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_v   <= '0;
            pend0 <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                h_rd[i]   <= '0;
                h_data[i] <= '0;
            end
        end else if (bus.flush) begin
            h_v   <= '0;
            pend0 <= 1'b0;
        end else if (bus.advance) begin
            for (int i = 1; i < DEPTH; i++) begin
                h_v[i]    <= h_v[i-1];
                h_rd[i]   <= h_rd[i-1];
                h_data[i] <= ((i == 1) && pend0) ? bus.mem_rdata : h_data[i-1];
            end
            h_v[0]    <= bus.push_valid && (bus.push_rd != '0);
            h_rd[0]   <= bus.push_rd;
            h_data[0] <= bus.push_data;
            pend0     <= bus.push_valid && bus.push_is_load;
        end
    end

    // History is masked while reset is held so outputs look cleared before the first edge.
    always_comb begin
        bus.src_data = bus.rf_data;
        bus.src_sel  = '0;
        hit          = '0;
        hazard       = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (bus.src_rs[s*RBITS +: RBITS] != '0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!hit[s] && reset_n && h_v[i] &&
                        (h_rd[i] == bus.src_rs[s*RBITS +: RBITS])) begin
                        hit[s] = 1'b1;
                        if ((i == 0) && pend0) begin
                            hazard[s] = bus.src_en[s];
                        end else begin
                            bus.src_data[s*XLEN +: XLEN] = h_data[i];
                            bus.src_sel[s*SBITS +: SBITS] = SBITS'(i + 1);
                        end
                    end
                end
            end
        end
        bus.stall = |hazard;
    end

`ifdef FWD_STATS_EN
    logic any_fwd;

    always_comb begin
        any_fwd = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (bus.src_en[s] && (bus.src_sel[s*SBITS +: SBITS] != '0)) begin
                any_fwd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fwd_hits     <= '0;
            stall_cycles <= '0;
        end else begin
            if (bus.advance && !bus.stall && any_fwd && (fwd_hits != '1)) begin
                fwd_hits <= fwd_hits + 32'd1;
            end
            if (bus.stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif
endmodule
